// File: rtl/sram_req_ctrl_pkg.sv
// Shared types for the SRAM request controller: FSM state encoding only.
// No logic, no latency, no flow control.
package sram_req_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/sram_req_ctrl.sv
// Single-port async SRAM controller: write done 1 cycle after accept, read response 3 cycles after accept.
// req_ready only in IDLE; RESP holds rsp_valid/rsp_rdata until rsp_ready, blocking new requests.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  busy
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    cs_d, we_d, oe_d;
  logic                    drive_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
      end
      if (state_q == RD_DATA) begin
        rdata_q <= mem_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    oe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: begin
        cs_d    = 1'b1;
        oe_d    = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        cs_d    = 1'b1;
        oe_d    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked by rst so an access aborted by reset never reaches the RAM
  // on the reset edge itself.
  assign mem_cs   = cs_d & ~rst;
  assign mem_we   = we_d & ~rst;
  assign mem_oe   = oe_d & ~rst;
  assign drive_en = (state_q == WR) & we_q & ~rst;

  assign mem_data  = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};
  assign mem_addr  = addr_q;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural async SRAM on the shared data bus.
// Inputs change 1ns after the rising edge; outputs are sampled there too, bus monitor on the falling edge.
module tb_sram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata, mem_addr;
  wire  [7:0] mem_data;
  logic       mem_cs, mem_we, mem_oe, busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] ram [256];

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .busy(busy)
  );

  // Async SRAM: combinational read when selected with OE, write sampled on the clock edge.
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram[mem_addr] : 8'bz;
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mem_oe) begin
      chk("bus_oe_we_low", {31'd0, mem_we}, 32'd0);
      chk("bus_read_value", {24'd0, mem_data}, {24'd0, ram[mem_addr]});
    end
  end

  // Present a request and advance past the accepting edge.
  task automatic handshake(input logic we, input logic [7:0] a, input logic [7:0] d);
    int waited;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    waited = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!req_ready) chk("hs_timeout", 32'd0, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    handshake(1'b1, a, d);
    tick();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output int lat);
    handshake(1'b0, a, 8'h00);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    d = rsp_rdata;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_mem_addr",  {24'd0, mem_addr},  32'd0);
    chk("rst_strobes",   {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);

    // Ready-side handshake with nothing outstanding must be inert.
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("idle_rsp_ready_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_rsp_ready_busy",  {31'd0, busy}, 32'd0);

    // Single write then read back, with response latency measured from the handshake cycle.
    do_write(8'h3C, 8'hA5);
    chk("wr_ram_3c", {24'd0, ram[8'h3C]}, 32'hA5);
    do_read(8'h3C, rd, lat);
    chk("rd_3c_data", {24'd0, rd}, 32'hA5);
    chk("rd_3c_latency", lat, 32'd3);
    chk("mem_addr_hold", {24'd0, mem_addr}, 32'h3C);

    // Back-to-back write sweep with req_valid held: ready alternates 1/0.
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      req_addr = 8'(i); req_wdata = 8'(i);
      chk("sweep_ready_hi", {31'd0, req_ready}, 32'd1);
      tick();
      chk("sweep_ready_lo", {31'd0, req_ready}, 32'd0);
      chk("sweep_we", {31'd0, mem_we}, 32'd1);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      do_read(8'(i), rd, lat);
      chk("sweep_readback", {24'd0, rd}, i);
    end

    // Stalled response: outputs hold and a pending write is refused while in RESP.
    handshake(1'b0, 8'h55, 8'h00);
    tick(); tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h66; req_wdata = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", {24'd0, rsp_rdata}, 32'h55);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("stall_no_write", {24'd0, ram[8'h66]}, 32'h66);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("stall_release_ready", {31'd0, req_ready}, 32'd1);
    chk("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("stall_then_wr_we",   {31'd0, mem_we}, 32'd1);
    chk("stall_then_wr_addr", {24'd0, mem_addr}, 32'h66);
    tick();
    do_read(8'h66, rd, lat);
    chk("stall_then_wr_data", {24'd0, rd}, 32'hEE);

    // Reset landing in WR: no write may reach the RAM.
    handshake(1'b1, 8'h20, 8'h99);
    chk("abort_wr_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_wr_idle",    {31'd0, req_ready}, 32'd1);
    chk("abort_wr_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    chk("abort_wr_ram",     {24'd0, ram[8'h20]}, 32'h20);

    // Reset landing in RD_DATA: no response, read data register cleared.
    handshake(1'b0, 8'h30, 8'h00);
    tick();
    chk("abort_rd_oe", {31'd0, mem_oe}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rd_idle",    {31'd0, busy}, 32'd0);
    chk("abort_rd_valid",   {31'd0, rsp_valid}, 32'd0);
    chk("abort_rd_rdata",   {24'd0, rsp_rdata}, 32'd0);
    chk("abort_rd_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    do_read(8'h20, rd, lat);
    chk("abort_wr_readback", {24'd0, rd}, 32'h20);
    do_read(8'h30, rd, lat);
    chk("abort_rd_readback", {24'd0, rd}, 32'h30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
